// File: rtl/fp_cvt_sched.sv
// fp_cvt_sched: shares one combinational fp32-to-int converter among NREQ requesters.
//
// A round-robin arbiter admits at most one conversion per cycle into a
// registered issue stage (S1). S1 drives the shared converter directly. The
// converter result is captured in the same cycle into a 2-entry output FIFO.
// The FIFO returns results on a single tagged response channel.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_src0/req_src1     per-requester fp32 operand / signed exponent adjust
//   cvt_src0/cvt_src1     operands driven to the shared converter (held when idle)
//   cvt_out               converter result, combinational from cvt_src0/cvt_src1
//   rsp_*                 head-of-FIFO response with id, NaN and range flags
//   sat_count             saturating count of saturated (7fffffff/80000000) results
//   busy                  issue stage or FIFO occupied
module fp_cvt_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int WID  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_src0,
  input  logic [NREQ*6-1:0] req_src1,
  output logic [31:0]       cvt_src0,
  output logic [5:0]        cvt_src1,
  input  logic [31:0]       cvt_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_nan,
  output logic              rsp_range_err,
  output logic [15:0]       sat_count,
  output logic              busy
);

  typedef struct packed {
    logic [31:0]    data;
    logic [IDW-1:0] id;
    logic           nan;
    logic           range_err;
  } fifo_entry_t;

  // Issue stage and arbitration state
  logic           s1_valid;
  logic [31:0]    s1_src0;
  logic [5:0]     s1_src1;
  logic [IDW-1:0] s1_id;
  logic [IDW-1:0] rr_ptr;

  // Output FIFO
  fifo_entry_t fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_count;

  logic           pop;
  logic           push;
  logic [2:0]     occ;
  logic           can_issue;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] grant_id;
  logic           found;
  logic [IDW-1:0] cand;
  logic signed [31:0] hi_bits;
  logic           range_err;
  logic           is_sat;
  fifo_entry_t    wr_entry;

  assign pop  = (fifo_count != 2'd0) && rsp_ready;
  assign push = s1_valid;

  // Occupancy after this cycle's pop; a new grant is only allowed when it
  // cannot overflow the FIFO one cycle later, so S1 never stalls.
  assign occ       = 3'(s1_valid) + 3'(fifo_count) - 3'(pop);
  assign can_issue = (occ < 3'd2);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    if (can_issue && !rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = IDW'((int'(rr_ptr) + k) % NREQ);
        if (!found && req_valid[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_id    = cand;
        end
      end
    end
  end

  assign req_ready = grant;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_src0  <= '0;
      s1_src1  <= '0;
      s1_id    <= '0;
      rr_ptr   <= IDW'(NREQ - 1);
    end else begin
      s1_valid <= found;
      if (found) begin
        s1_src0 <= req_src0[32*grant_id +: 32];
        s1_src1 <= req_src1[6*grant_id +: 6];
        s1_id   <= grant_id;
        rr_ptr  <= grant_id;
      end
    end
  end

  assign cvt_src0 = s1_src0;
  assign cvt_src1 = s1_src1;

  // Result fits a signed WID-bit integer when bits [31:WID-1] are all equal,
  // i.e. the arithmetic shift leaves only sign copies. Always fits for WID=32.
  assign hi_bits   = $signed(cvt_out) >>> (WID - 1);
  assign range_err = (hi_bits != 32'sd0) && (hi_bits != -32'sd1);
  assign is_sat    = (cvt_out == 32'h7fff_ffff) || (cvt_out == 32'h8000_0000);

  assign wr_entry = '{data: cvt_out, id: s1_id,
                      nan: (s1_src0[30:23] == 8'hff), range_err: range_err};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      sat_count  <= 16'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + 2'(push) - 2'(pop);
      if (push && is_sat && (sat_count != 16'hffff))
        sat_count <= sat_count + 16'd1;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wr_entry;
  end

  // The admission rule keeps at least one free slot whenever S1 holds a result.
  always_ff @(posedge clk) begin
    if (!rst && s1_valid) assert (fifo_count != 2'd2);
  end

  assign rsp_valid     = (fifo_count != 2'd0);
  assign rsp_data      = fifo_mem[rd_ptr].data;
  assign rsp_id        = fifo_mem[rd_ptr].id;
  assign rsp_nan       = fifo_mem[rd_ptr].nan;
  assign rsp_range_err = fifo_mem[rd_ptr].range_err;
  assign busy          = s1_valid || (fifo_count != 2'd0);

endmodule

// File: tb/tb_fp_cvt_sched.sv
// Directed testbench for fp_cvt_sched (NREQ=4, WID=16). A behavioural
// truncating fp32-to-int converter with saturation stands in for the shared
// converter; expected values below are hand-computed from that behaviour.
module tb_fp_cvt_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int WID  = 16;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_src0;
  logic [NREQ*6-1:0] req_src1;
  logic [31:0]       cvt_src0;
  logic [5:0]        cvt_src1;
  logic [31:0]       cvt_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_nan;
  logic              rsp_range_err;
  logic [15:0]       sat_count;
  logic              busy;

  int total;
  int bad;

  fp_cvt_sched #(.NREQ(NREQ), .IDW(IDW), .WID(WID)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src0(req_src0), .req_src1(req_src1),
    .cvt_src0(cvt_src0), .cvt_src1(cvt_src1), .cvt_out(cvt_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_nan(rsp_nan), .rsp_range_err(rsp_range_err),
    .sat_count(sat_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncate toward zero, saturate out-of-range and Inf/NaN, flush denormals.
  function automatic logic [31:0] fcvt(input logic [31:0] f, input logic [5:0] adj);
    int          e;
    logic [63:0] mag;
    if (f[30:23] == 8'hff) return f[31] ? 32'h8000_0000 : 32'h7fff_ffff;
    if (f[30:23] == 8'h00) return 32'h0;
    e   = int'(f[30:23]) - 150 + int'($signed(adj));
    mag = {40'd0, 1'b1, f[22:0]};
    if (e > 8)        mag = 64'h1_0000_0000;
    else if (e >= 0)  mag = mag << e;
    else if (e > -25) mag = mag >> (-e);
    else              mag = 64'd0;
    if (f[31]) return (mag > 64'h8000_0000) ? 32'h8000_0000 : 32'(64'd0 - mag);
    return (mag > 64'h7fff_ffff) ? 32'h7fff_ffff : mag[31:0];
  endfunction

  always_comb cvt_out = fcvt(cvt_src0, cvt_src1);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [31:0] s0, input logic [5:0] s1);
    req_src0[32*i +: 32] = s0;
    req_src1[6*i +: 6]   = s1;
  endtask

  task automatic set_default_lanes();
    set_lane(0, 32'h3f80_0000, 6'd0);  // 1.0    -> 1
    set_lane(1, 32'h4000_0000, 6'd0);  // 2.0    -> 2
    set_lane(2, 32'hc0b0_0000, 6'd0);  // -5.5   -> -5
    set_lane(3, 32'h42c8_0000, 6'd2);  // 100*4  -> 400
  endtask

  // Issue one request on lane 0 with an otherwise idle design; returns with
  // the response at the FIFO head (two cycles after the grant).
  task automatic send_one(input string tag, input logic [31:0] s0, input logic [5:0] s1);
    set_lane(0, s0, s1);
    req_valid = 4'b0001;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    tick();
    check({tag, "_valid"}, 32'(rsp_valid), 32'h1);
  endtask

  logic [31:0] exp_data [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    exp_data[0] = 32'h0000_0001;
    exp_data[1] = 32'h0000_0002;
    exp_data[2] = 32'hffff_fffb;
    exp_data[3] = 32'h0000_0190;

    rst       = 1'b1;
    req_valid = '0;
    req_src0  = '0;
    req_src1  = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    // Reset state
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_cvt_src0",  cvt_src0,       32'h0);
    check("rst_cvt_src1",  32'(cvt_src1),  32'h0);
    check("rst_sat",       32'(sat_count), 32'h0);
    check("rst_ready",     32'(req_ready), 32'h0);

    // Single request on lane 2: pi -> 3, response two cycles after grant
    set_lane(2, 32'h4049_0fdb, 6'd0);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    check("single_cvt_src0", cvt_src0, 32'h4049_0fdb);
    check("single_t1_valid", 32'(rsp_valid), 32'h0);
    check("single_t1_busy",  32'(busy), 32'h1);
    tick();
    check("single_valid", 32'(rsp_valid), 32'h1);
    check("single_data",  rsp_data, 32'h3);
    check("single_id",    32'(rsp_id), 32'h2);
    check("single_nan",   32'(rsp_nan), 32'h0);
    check("single_rerr",  32'(rsp_range_err), 32'h0);
    tick();
    check("single_drained", 32'(rsp_valid), 32'h0);
    check("single_idle",    32'(busy), 32'h0);
    check("single_hold",    cvt_src0, 32'h4049_0fdb);

    // Round robin after reset with all lanes valid and consumer always ready
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_default_lanes();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 2) begin
        check($sformatf("rr_valid%0d", k), 32'(rsp_valid), 32'h1);
        check($sformatf("rr_id%0d", k),    32'(rsp_id),    32'((k - 2) % 4));
        check($sformatf("rr_data%0d", k),  rsp_data,       exp_data[(k - 2) % 4]);
      end
      tick();
    end
    req_valid = 4'b0000;
    repeat (3) tick();
    check("rr_drained", 32'(busy), 32'h0);

    // Backpressure: last grant was lane 3, so lanes 0 and 1 are admitted, then stall
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    #1;
    check("bp_grant0", 32'(req_ready), 32'h1);
    tick();
    check("bp_grant1", 32'(req_ready), 32'h2);
    tick();
    check("bp_stall2",  32'(req_ready), 32'h0);
    check("bp_head_id", 32'(rsp_id), 32'h0);
    tick();
    check("bp_stall3",  32'(req_ready), 32'h0);
    check("bp_busy",    32'(busy), 32'h1);
    tick();
    check("bp_stall4",  32'(req_ready), 32'h0);
    check("bp_head_data", rsp_data, 32'h1);
    rsp_ready = 1'b1;
    #1;
    check("bp_resume", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    check("bp_id1", 32'(rsp_id), 32'h1);
    tick();
    check("bp_id2",   32'(rsp_id), 32'h2);
    check("bp_data2", rsp_data, 32'hffff_fffb);
    tick();
    check("bp_empty", 32'(rsp_valid), 32'h0);

    // Special values (WID=16 range check)
    send_one("inf", 32'h7f80_0000, 6'd0);
    check("inf_nan",  32'(rsp_nan), 32'h1);
    check("inf_data", rsp_data, 32'h7fff_ffff);
    tick();
    send_one("big", 32'h4f80_0000, 6'd0);
    check("big_data", rsp_data, 32'h7fff_ffff);
    check("big_nan",  32'(rsp_nan), 32'h0);
    check("big_rerr", 32'(rsp_range_err), 32'h1);
    tick();
    check("big_sat", 32'(sat_count), 32'h2);
    send_one("p32768", 32'h4700_0000, 6'd0);
    check("p32768_data", rsp_data, 32'h0000_8000);
    check("p32768_rerr", 32'(rsp_range_err), 32'h1);
    tick();
    send_one("n32768", 32'hc700_0000, 6'd0);
    check("n32768_data", rsp_data, 32'hffff_8000);
    check("n32768_rerr", 32'(rsp_range_err), 32'h0);
    tick();
    send_one("p32767", 32'h46ff_fe00, 6'd0);
    check("p32767_data", rsp_data, 32'h0000_7fff);
    check("p32767_rerr", 32'(rsp_range_err), 32'h0);
    tick();
    send_one("adj_pos", 32'h3f80_0000, 6'd5);
    check("adj_pos_data", rsp_data, 32'h0000_0020);
    tick();
    send_one("adj_neg", 32'h42c8_0000, 6'h3e);
    check("adj_neg_data", rsp_data, 32'h0000_0019);
    tick();
    check("special_sat", 32'(sat_count), 32'h2);

    // Reset while S1 and the FIFO are both occupied
    set_default_lanes();
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    tick();
    tick();
    check("mid_busy",  32'(busy), 32'h1);
    check("mid_valid", 32'(rsp_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_busy0",     32'(busy), 32'h0);
    check("mid_sat0",      32'(sat_count), 32'h0);
    check("mid_grant",     32'(req_ready), 32'h1);
    rsp_ready = 1'b1;
    tick();
    req_valid = 4'b0000;
    tick();
    check("mid_id",   32'(rsp_id), 32'h0);
    check("mid_data", rsp_data, 32'h1);
    tick();
    check("mid_no_stale", 32'(rsp_valid), 32'h0);

    // Saturating counter: 70000 saturated results
    set_lane(0, 32'h4f80_0000, 6'd0);
    req_valid = 4'b0001;
    repeat (70000) tick();
    req_valid = 4'b0000;
    repeat (3) tick();
    check("satcnt_hold", 32'(sat_count), 32'hffff);
    check("satcnt_idle", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_cvt_sched.md
Name: fp_cvt_sched

Overview:
- Shares one combinational float-to-int converter (fp32 in, 6-bit signed exponent adjust, 32-bit signed int out) among NREQ requesters.
- Round-robin arbitration admits at most one conversion per cycle and drives the converter's operands from a registered issue stage.
- Results are captured into a 2-entry output FIFO and returned on a single tagged response channel with backpressure.
- Sits between the vector lanes' convert ops and the shared converter instance.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester id width, must equal clog2(NREQ)
WID, 32, legal destination integer width for the range check (1..32)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept (one-hot or zero)
req_src0  input  NREQ*32  per-requester fp32 operand, lane i at [32*i+31:32*i]
req_src1  input  NREQ*6  per-requester signed exponent adjust, lane i at [6*i+5:6*i]
cvt_src0  output  32  operand to shared converter
cvt_src1  output  6  exponent adjust to shared converter
cvt_out  input  32  converter result (combinational from cvt_src0/cvt_src1)
rsp_valid  output  1  response available
rsp_ready  input  1  response consumer accept
rsp_data  output  32  converted integer
rsp_id  output  IDW  index of the originating requester
rsp_nan  output  1  source exponent field was 8'hff (NaN/Inf)
rsp_range_err  output  1  rsp_data does not fit a signed WID-bit integer
sat_count  output  16  saturating count of results equal to 32'h7fffffff or 32'h80000000
busy  output  1  issue stage or FIFO occupied

Behaviour:
- Reset (sync, rst=1 at posedge):
  - s1_valid=0, FIFO emptied, rr_ptr=NREQ-1 (requester 0 has top priority first), sat_count=0.
  - Outputs: rsp_valid=0, req_ready=0, busy=0, cvt_src0=0, cvt_src1=0.
  - Reset mid-operation drops all in-flight and queued results; no response is produced for them.
- Admission:
  - pop = rsp_valid & rsp_ready.
  - can_issue = (s1_valid + fifo_count - pop) < 2.
  - If can_issue, grant the first asserted req_valid searching from rr_ptr+1 upward, wrapping modulo NREQ.
  - req_ready = grant, combinational. Requesters must hold valid and operands stable until ready.
  - rr_ptr updates to the granted index only on a grant; with no grant it is unchanged.
- Issue stage S1:
  - On grant, register src0, src1 and id; s1_valid=1 next cycle. Otherwise s1_valid=0.
  - cvt_src0/cvt_src1 are driven directly from the S1 registers and hold their value when idle.
  - While s1_valid, cvt_out is sampled in the same cycle and written to the FIFO with id, nan = (s1_src0[30:23]==8'hff), and range_err.
  - range_err = cvt_out[31:WID-1] not all-equal. It is 0 when WID=32.
- Output FIFO: depth 2.
  - rsp_* reflect the head entry; rsp_valid = fifo_count != 0.
  - Simultaneous write and pop is legal at any count.
  - The admission rule guarantees there is never a write when the FIFO is full; an assertion checks this.
- Latency and throughput:
  - Grant at cycle T gives rsp_valid at T+2 (earliest).
  - Sustains 1 result/cycle when rsp_ready is held high.
  - With rsp_ready low, at most 2 results are buffered and no further grants occur.
- sat_count: increments on each FIFO write whose data is 7fffffff or 80000000; sticks at 16'hffff.
- busy = s1_valid | (fifo_count != 0).
- Ordering: responses return in grant order.

Test Plan:
- Single request: lane 2 sends src0=32'h40490fdb (3.14159), src1=0 → granted the same cycle; two cycles later rsp_valid=1, rsp_data=3, rsp_id=2, rsp_nan=0, rsp_range_err=0.
- All 4 lanes valid continuously after reset, rsp_ready=1 → grants in order 0,1,2,3,0,…; one rsp per cycle; rsp_id sequence matches the grant order.
- rsp_ready=0 with all lanes valid → exactly 2 grants, then req_ready=0 for all lanes. Raising rsp_ready → grants resume the same cycle as the first pop, and the round-robin order continues from rr_ptr.
- src0=32'h7f800000 (Inf) → rsp_nan=1. src0=32'h4f800000 (2^32) → rsp_data=7fffffff and sat_count increments. With WID=16, src0=32'h47000000 (32768) → rsp_range_err=1; src0=32'hc7000000 (-32768) → rsp_range_err=0.
- Assert rst while S1 and the FIFO are both occupied → the next cycle has rsp_valid=0, busy=0, sat_count=0; the first subsequent grant goes to lane 0 when all lanes are valid.
- Drive 70000 saturating conversions → sat_count holds at 16'hffff.
